// File: rtl/adc_capture_buffer_pkg.sv
// Shared types and default geometry for the ADC capture buffer.
package adc_capture_buffer_pkg;

  localparam int unsigned DEF_NTI    = 16;
  localparam int unsigned DEF_NADC   = 8;
  localparam int unsigned N_mem_addr = 10;

  typedef enum logic [1:0] {
    MODE_TRIG      = 2'd0,
    MODE_PRETRIG   = 2'd1,
    MODE_IMMEDIATE = 2'd2
  } capture_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_ARMED,
    ST_POST,
    ST_DONE
  } capture_state_t;

  // Encoding 3 is an alias of IMMEDIATE.
  function automatic capture_mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'd0:    return MODE_TRIG;
      2'd1:    return MODE_PRETRIG;
      default: return MODE_IMMEDIATE;
    endcase
  endfunction

endpackage

// File: rtl/adc_capture_buffer_capture_sram.sv
// 1W1R synchronous SRAM, 1-cycle registered read; behavioural stand-in for the hard macro.
module adc_capture_buffer_capture_sram #(
  parameter int unsigned W  = 128,
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register holds its value between reads and clears on reset.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/adc_capture_buffer.sv
// Trigger-controlled snapshot buffer for the interleaved ADC bus with trigger-relative readout.
// Optional decimation is enabled by defining CAPTURE_DECIM_EN.
module adc_capture_buffer
  import adc_capture_buffer_pkg::*;
#(
  parameter int unsigned Nti   = DEF_NTI,
  parameter int unsigned Nadc  = DEF_NADC,
  parameter int unsigned Naddr = N_mem_addr
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [Nti*Nadc-1:0]   in_data,
  input  logic [1:0]            mode,
  input  logic                  arm,
  input  logic                  trig,
  input  logic [Naddr-1:0]      pretrig_len,
`ifdef CAPTURE_DECIM_EN
  input  logic [3:0]            decim,
`endif
  input  logic                  rd_en,
  input  logic [Naddr-1:0]      rd_addr,
  output logic [Nti*Nadc-1:0]   rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned W     = Nti * Nadc;
  localparam int unsigned CW    = Naddr + 1;
  localparam int unsigned DEPTH = 2 ** Naddr;

  capture_state_t   state_q, state_d;
  capture_mode_t    mode_q, mode_in;
  logic [Naddr-1:0] pre_len_q, wr_ptr_q, start_q, pre_eff;
  logic [CW-1:0]    cnt_q, cnt_d, post_target;
  logic             accept, we, load_cfg, set_start;

`ifdef CAPTURE_DECIM_EN
  logic [3:0] decim_q, dcnt_q;
  assign accept = in_valid && (dcnt_q == '0);
`else
  assign accept = in_valid;
`endif

  assign mode_in     = decode_mode(mode);
  assign pre_eff     = (mode_q == MODE_PRETRIG) ? pre_len_q : '0;
  assign post_target = CW'(DEPTH) - {1'b0, pre_eff};

  // cnt_q counts pre-trigger beats in PRE and post-trigger beats from the trigger on.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we        = 1'b0;
    load_cfg  = 1'b0;
    set_start = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          load_cfg = 1'b1;
          cnt_d    = '0;
          unique case (mode_in)
            MODE_PRETRIG: state_d = (pretrig_len == '0) ? ST_ARMED : ST_PRE;
            MODE_TRIG:    state_d = ST_ARMED;
            default:      state_d = ST_POST;
          endcase
        end
      end
      ST_PRE: begin
        we    = accept;
        cnt_d = cnt_q + CW'(accept);
        if (cnt_d == {1'b0, pre_len_q}) begin
          state_d = ST_ARMED;
          cnt_d   = '0;
        end
      end
      ST_ARMED: begin
        we = accept && ((mode_q == MODE_PRETRIG) || trig);
        if (trig) begin
          set_start = 1'b1;
          cnt_d     = CW'(accept);
          state_d   = (cnt_d == post_target) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        we    = accept;
        cnt_d = cnt_q + CW'(accept);
        if (cnt_d == post_target) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_TRIG;
      pre_len_q <= '0;
      wr_ptr_q  <= '0;
      start_q   <= '0;
      cnt_q     <= '0;
      rd_valid  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_valid <= rd_en;
      if (load_cfg) begin
        mode_q    <= mode_in;
        pre_len_q <= pretrig_len;
        wr_ptr_q  <= '0;
        start_q   <= '0;
      end else begin
        if (we)        wr_ptr_q <= wr_ptr_q + Naddr'(1);
        if (set_start) start_q  <= wr_ptr_q - pre_eff;
      end
    end
  end

`ifdef CAPTURE_DECIM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      decim_q <= '0;
      dcnt_q  <= '0;
    end else if (load_cfg) begin
      decim_q <= decim;
      dcnt_q  <= '0;
    end else if (in_valid) begin
      dcnt_q <= (dcnt_q == decim_q) ? '0 : dcnt_q + 4'd1;
    end
  end
`endif

  assign busy = (state_q == ST_PRE) || (state_q == ST_ARMED) || (state_q == ST_POST);
  assign done = (state_q == ST_DONE);

  adc_capture_buffer_capture_sram #(
    .W  (W),
    .AW (Naddr)
  ) u_sram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .re    (rd_en),
    .raddr (start_q + rd_addr),
    .rdata (rd_data)
  );

endmodule
